// File: rtl/xnor_reduce_pipe.sv
// Pipelined NIN-operand XOR/XNOR gate array with valid/ready flow control.
// Result is extended to OUT_W and parity-reduced before the first register stage.
module xnor_reduce_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NIN    = 3,
  parameter int unsigned STAGES = 2,
  parameter int unsigned OUT_W  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIN*WIDTH-1:0]   in_data,
  input  logic                   in_xnor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_par
);

  logic [WIDTH-1:0]  res;
  logic [OUT_W-1:0]  ext;

  logic [STAGES-1:0] v_q, v_d, v_in, adv, ld, pl;
  logic [STAGES-1:0] par_q, par_d;
  logic [OUT_W-1:0]  data_q [STAGES];
  logic [OUT_W-1:0]  data_d [STAGES];

  // XNOR is XOR seeded with all-ones, so a single operand is simply inverted.
  always_comb begin
    res = {WIDTH{in_xnor}};
    for (int unsigned k = 0; k < NIN; k++) begin
      res = res ^ in_data[k*WIDTH +: WIDTH];
    end
    ext = '0;
    ext[WIDTH-1:0] = res;
    for (int unsigned i = WIDTH; i < OUT_W; i++) begin
      ext[i] = SIGNED ? res[WIDTH-1] : 1'b0;
    end
  end

  // Stall chain walks from the output back to the input; nxt carries adv[s+1].
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = v_q[STAGES-1] & out_ready;
    adv[STAGES-1] = nxt;
    for (int unsigned k = 1; k < STAGES; k++) begin
      nxt = v_q[STAGES-1-k] & (~v_q[STAGES-k] | nxt);
      adv[STAGES-1-k] = nxt;
    end
    ld       = ~v_q | adv;
    in_ready = rst_n & ld[0];
  end

  always_comb begin
    v_in[0]   = in_valid;
    data_d[0] = ext;
    par_d[0]  = ^res;
    for (int unsigned s = 1; s < STAGES; s++) begin
      v_in[s]   = v_q[s-1];
      data_d[s] = data_q[s-1];
      par_d[s]  = par_q[s-1];
    end
    v_d = (ld & v_in) | (~ld & v_q);
    pl  = ld & v_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      par_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (pl[s]) begin
          data_q[s] <= data_d[s];
          par_q[s]  <= par_d[s];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_par   = par_q[STAGES-1];

endmodule

// File: tb/tb_xnor_reduce_pipe.sv
// Bench for xnor_reduce_pipe: zero-extend, sign-extend and single-operand instances
// share handshake stimulus and are checked against a queue model every cycle.
module tb_xnor_reduce_pipe;
  localparam int unsigned W  = 4;
  localparam int unsigned N  = 3;
  localparam int unsigned S  = 2;
  localparam int unsigned OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_xnor = 1'b0, out_ready = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [W-1:0]   in_data1 = '0;

  logic rdy_z, rdy_s, rdy_1, ov_z, ov_s, ov_1, op_z, op_s, op_1;
  logic [OW-1:0] od_z, od_s, od_1;

  always #5 clk = ~clk;

  xnor_reduce_pipe #(.WIDTH(W), .NIN(N), .STAGES(S), .OUT_W(OW), .SIGNED(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_z), .in_data(in_data),
    .in_xnor(in_xnor), .out_valid(ov_z), .out_ready(out_ready), .out_data(od_z), .out_par(op_z));
  xnor_reduce_pipe #(.WIDTH(W), .NIN(N), .STAGES(S), .OUT_W(OW), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
    .in_xnor(in_xnor), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s), .out_par(op_s));
  xnor_reduce_pipe #(.WIDTH(W), .NIN(1), .STAGES(S), .OUT_W(OW), .SIGNED(1'b0)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_1), .in_data(in_data1),
    .in_xnor(in_xnor), .out_valid(ov_1), .out_ready(out_ready), .out_data(od_1), .out_par(op_1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [OW-1:0] z, s, n1;
    logic          p, p1;
    int            stamp;
  } exp_t;

  exp_t q[$];
  int edges = 0;
  int acc_cnt = 0, pop_cnt = 0;

  function automatic exp_t model(input logic [N*W-1:0] d, input logic [W-1:0] d1,
                                 input logic x, input int stamp);
    exp_t e;
    logic [W-1:0] ops [N];
    logic [W-1:0] r;
    logic [W-1:0] r1;
    for (int k = 0; k < N; k++) ops[k] = d[k*W +: W];
    r = '0;
    for (int k = 0; k < N; k++) r = r ^ ops[k];
    if (x) r = ~r;
    r1 = x ? ~d1 : d1;
    e.z  = {4'h0, r};
    e.s  = {{4{r[W-1]}}, r};
    e.p  = ^r;
    e.n1 = {4'h0, r1};
    e.p1 = ^r1;
    e.stamp = stamp;
    return e;
  endfunction

  always @(posedge clk) edges++;

  // Oldest beat is never blocked by anything ahead, so it surfaces S-1 edges after loading.
  always @(negedge clk) begin
    logic exp_valid, exp_ready;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 64'(ov_z), 64'(0));
      chk("rst_out_data", 64'(od_z), 64'(0));
      chk("rst_in_ready", 64'(rdy_z), 64'(0));
    end else begin
      exp_valid = (q.size() > 0) && (edges >= q[0].stamp + int'(S) - 1);
      exp_ready = (q.size() < int'(S)) || out_ready;
      chk("in_ready_z", 64'(rdy_z), 64'(exp_ready));
      chk("in_ready_s", 64'(rdy_s), 64'(exp_ready));
      chk("in_ready_1", 64'(rdy_1), 64'(exp_ready));
      chk("out_valid_z", 64'(ov_z), 64'(exp_valid));
      chk("out_valid_s", 64'(ov_s), 64'(exp_valid));
      chk("out_valid_1", 64'(ov_1), 64'(exp_valid));
      if (exp_valid) begin
        chk("out_data_z", 64'(od_z), 64'(q[0].z));
        chk("out_par_z", 64'(op_z), 64'(q[0].p));
        chk("out_data_s", 64'(od_s), 64'(q[0].s));
        chk("out_par_s", 64'(op_s), 64'(q[0].p));
        chk("out_data_1", 64'(od_1), 64'(q[0].n1));
        chk("out_par_1", 64'(op_1), 64'(q[0].p1));
      end
      if (ov_z && out_ready) pop_cnt++;
      if (in_valid && rdy_z) acc_cnt++;
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) q.push_back(model(in_data, in_data1, in_xnor, edges + 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic one_beat(input logic [N*W-1:0] d, input logic [W-1:0] d1, input logic x,
                          input logic [7:0] ez, input logic [7:0] es, input logic ep,
                          input logic [7:0] e1);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_data1 = d1; in_xnor = x; out_ready = 1'b1;
    @(negedge clk);
    chk("beat_accept", 64'(rdy_z), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ov_z && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(2));
    chk("lit_data_z", 64'(od_z), 64'(ez));
    chk("lit_data_s", 64'(od_s), 64'(es));
    chk("lit_par", 64'(op_z), 64'(ep));
    chk("lit_data_1", 64'(od_1), 64'(e1));
  endtask

  logic [N*W-1:0] bd [3];
  logic           bx [3];

  initial begin
    int acc, bi, stale, acc0, pop0;
    logic last_acc;
    bd[0] = 12'h16A; bx[0] = 1'b1;
    bd[1] = 12'h16A; bx[1] = 1'b0;
    bd[2] = 12'hFFF; bx[2] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(ov_z), 64'(0));
    chk("reset_data", 64'(od_z), 64'(0));
    chk("reset_ready", 64'(rdy_z), 64'(0));
    rst_n = 1'b1;

    // c=0001 b=0110 a=1010 packed as {c,b,a}
    one_beat(12'h16A, 4'hA, 1'b1, 8'h02, 8'h02, 1'b1, 8'h05);
    one_beat(12'h16A, 4'hA, 1'b0, 8'h0D, 8'hFD, 1'b1, 8'h0A);
    one_beat(12'hFFF, 4'hF, 1'b0, 8'h0F, 8'hFF, 1'b0, 8'h0F);
    one_beat(12'hFFF, 4'hF, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);

    // Backpressure: capacity fill, then simultaneous pop and accept.
    @(posedge clk); #1;
    out_ready = 1'b0; bi = 0; acc = 0;
    in_valid = 1'b1; in_data = bd[0]; in_xnor = bx[0];
    repeat (5) begin
      @(negedge clk);
      last_acc = rdy_z;
      if (last_acc) acc++;
      @(posedge clk); #1;
      if (last_acc && bi < 2) begin
        bi++;
        in_data = bd[bi]; in_xnor = bx[bi];
      end
    end
    chk("stall_accept_count", 64'(acc), 64'(2));
    chk("stall_in_ready", 64'(rdy_z), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop1_valid", 64'(ov_z), 64'(1));
    chk("pop1_data", 64'(od_z), 64'(8'h02));
    chk("pop1_accept_same", 64'(rdy_z), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pop2_data", 64'(od_z), 64'(8'h0D));
    @(negedge clk);
    chk("pop3_data", 64'(od_z), 64'(8'h0F));
    repeat (3) @(negedge clk);

    // Mid-cycle reset with two beats held.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = bd[0]; in_xnor = bx[0];
    @(posedge clk); #1;
    in_data = bd[1]; in_xnor = bx[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(ov_z), 64'(0));
    chk("midrst_data", 64'(od_z), 64'(0));
    chk("midrst_par", 64'(op_z), 64'(0));
    chk("midrst_ready", 64'(rdy_z), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov_z) stale++;
    end
    chk("no_stale_beat", 64'(stale), 64'(0));

    // Random handshake traffic.
    acc0 = acc_cnt; pop0 = pop_cnt;
    last_acc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 12'($urandom);
        in_data1 = 4'($urandom);
        in_xnor  = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_acc = in_valid && rdy_z;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_loss", 64'(pop_cnt - pop0), 64'(acc_cnt - acc0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
